mc_ctrl_fsm: RTL and testbench

//  Multicycle control sequencer driving the 22-bit ALU/datapath control word (ctrl_in) of the stage-3 ALU.

---
 rtl/mc_ctrl_fsm_if.sv | 43 ++++
 rtl/mc_ctrl_fsm.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm_if
//  Purpose  : Bundles the instruction fields, ALU status flags, memory and
//             exception handshakes, and control outputs exchanged between
//             the multicycle control sequencer and its datapath.
//  Modports : master - the sequencer (drives ctrl_out and the strobes)
//             slave  - the datapath side (drives op/fn, flags, acks)
//  Signals  : op[5:0], fn[5:0]   IR opcode / function field
//             alu_zero, ovfl     ALU status, combinational this cycle
//             mem_ack, exc_ack   memory completion / exception accepted
//             ctrl_out[CTRL_W]   datapath control word
//             mem_req, ir_we, pc_we, exc_valid, exc_cause[1:0], state_dbg[3:0]
//  Revision : 1.0  initial release
// ============================================================================
interface mc_ctrl_fsm_if #(
    parameter int CTRL_W = 22
);
    logic [5:0]        op;
    logic [5:0]        fn;
    logic              alu_zero;
    logic              ovfl;
    logic              mem_ack;
    logic              exc_ack;
    logic [CTRL_W-1:0] ctrl_out;
    logic              mem_req;
    logic              ir_we;
    logic              pc_we;
    logic              exc_valid;
    logic [1:0]        exc_cause;
    logic [3:0]        state_dbg;

    modport master (
        input  op, fn, alu_zero, ovfl, mem_ack, exc_ack,
        output ctrl_out, mem_req, ir_we, pc_we, exc_valid, exc_cause, state_dbg
    );

    modport slave (
        output op, fn, alu_zero, ovfl, mem_ack, exc_ack,
        input  ctrl_out, mem_req, ir_we, pc_we, exc_valid, exc_cause, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Purpose  : Multicycle control sequencer. Steps each instruction through
//             fetch / decode / execute / memory / writeback and produces the
//             22-bit ALU/datapath control word, memory request, IR/PC write
//             strobes and exception reporting.
//  Ports    : clk     rising-edge clock
//             reset   synchronous, active-high
//             bus     mc_ctrl_fsm_if.master (op, fn, alu_zero, ovfl, mem_ack,
//                     exc_ack in; ctrl_out, mem_req, ir_we, pc_we, exc_valid,
//                     exc_cause, state_dbg out)
//  Params   : CTRL_W      control word width (field map assumes 22)
//             MEM_TIMEOUT cycles allowed for mem_ack before a bus-error trap
//             TRAP_ON_OVF 1: add/sub/addi overflow traps, no register write
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int CTRL_W      = 22,
    parameter int MEM_TIMEOUT = 16,
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWR  = 4'd7,
        S_WB_MEM = 4'd8,
        S_WB_ALU = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_EXC    = 4'd12
    } state_t;

    // ---------------- control word field positions ----------------
    localparam int c_F_FNTYPE   = 0;   // 2 bits
    localparam int c_F_LOGICFN  = 2;   // 2 bits, [2] doubles as ADDSUB
    localparam int c_F_SRCY     = 4;
    localparam int c_F_SRCX     = 6;
    localparam int c_B_INST_WR  = 8;
    localparam int c_B_PC_WR    = 9;
    localparam int c_B_PC_WR_BR = 10;
    localparam int c_B_BR_NE    = 11;
    localparam int c_F_PCSRC    = 12;
    localparam int c_B_MEM_RD   = 14;
    localparam int c_B_MEM_WR   = 15;
    localparam int c_B_IORD     = 16;
    localparam int c_B_REG_WR   = 17;
    localparam int c_F_REGDST   = 18;
    localparam int c_F_REGDATA  = 20;

    // ---------------- field encodings ----------------
    localparam logic [1:0] c_T_ARITH  = 2'b00;
    localparam logic [1:0] c_T_LOGIC  = 2'b01;
    localparam logic [1:0] c_T_SHIFT  = 2'b10;
    localparam logic [1:0] c_T_SLT    = 2'b11;
    localparam logic [1:0] c_SH_SRL   = 2'b01;
    localparam logic [1:0] c_SH_SLL   = 2'b10;
    localparam logic [1:0] c_SH_SRA   = 2'b11;
    localparam logic [1:0] c_Y_Y      = 2'b01;
    localparam logic [1:0] c_Y_IMM    = 2'b10;
    localparam logic [1:0] c_Y_IMM2   = 2'b11;
    localparam logic [1:0] c_X_X      = 2'b01;
    localparam logic [1:0] c_PC_Z     = 2'b01;
    localparam logic [1:0] c_PC_JT    = 2'b10;
    localparam logic [1:0] c_PC_X     = 2'b11;
    localparam logic [1:0] c_DST_RT   = 2'b00;
    localparam logic [1:0] c_DST_RD   = 2'b01;
    localparam logic [1:0] c_DST_R31  = 2'b10;
    localparam logic [1:0] c_DATA_Z   = 2'b00;
    localparam logic [1:0] c_DATA_MEM = 2'b01;
    localparam logic [1:0] c_DATA_PC  = 2'b10;

    localparam logic [1:0] c_CAUSE_BUS = 2'b00;
    localparam logic [1:0] c_CAUSE_ILL = 2'b01;
    localparam logic [1:0] c_CAUSE_OVF = 2'b10;
    localparam logic [1:0] c_CAUSE_SYS = 2'b11;

    // ---------------- opcodes / function codes ----------------
    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_JAL   = 6'd3;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_BNE   = 6'd5;
    localparam logic [5:0] c_OP_ADDI  = 6'd8;
    localparam logic [5:0] c_OP_SLTI  = 6'd10;
    localparam logic [5:0] c_OP_ANDI  = 6'd12;
    localparam logic [5:0] c_OP_ORI   = 6'd13;
    localparam logic [5:0] c_OP_XORI  = 6'd14;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;

    localparam logic [5:0] c_FN_SLL   = 6'd0;
    localparam logic [5:0] c_FN_SRL   = 6'd2;
    localparam logic [5:0] c_FN_SRA   = 6'd3;
    localparam logic [5:0] c_FN_JR    = 6'd8;
    localparam logic [5:0] c_FN_SYS   = 6'd12;
    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_SUB   = 6'd34;
    localparam logic [5:0] c_FN_AND   = 6'd36;
    localparam logic [5:0] c_FN_OR    = 6'd37;
    localparam logic [5:0] c_FN_XOR   = 6'd38;
    localparam logic [5:0] c_FN_NOR   = 6'd39;
    localparam logic [5:0] c_FN_SLT   = 6'd42;

    localparam int                c_WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    // ---------------- registers ----------------
    state_t              r_state;
    logic [5:0]          r_op_q;
    logic [5:0]          r_fn_q;
    logic                r_ovf_q;
    logic [c_WAIT_W-1:0] r_wait;
    logic [1:0]          r_cause;

    // ---------------- combinational ----------------
    state_t              w_state_nxt;
    logic [1:0]          w_cause_nxt;
    logic [CTRL_W-1:0]   w_ctrl;
    logic                w_mem_req;
    logic                w_ir_we;
    logic                w_pc_we;
    logic                w_wait_st;
    logic                w_tmo;
    logic                w_ovf_op;
    logic                w_br_ne;

    // {LOGICFN, FNTYPE} for R-type function codes; add is the fallback.
    function automatic logic [3:0] f_rfn(input logic [5:0] fn);
        case (fn)
            c_FN_SUB: f_rfn = {2'b01,    c_T_ARITH};
            c_FN_AND: f_rfn = {2'b00,    c_T_LOGIC};
            c_FN_OR:  f_rfn = {2'b01,    c_T_LOGIC};
            c_FN_XOR: f_rfn = {2'b10,    c_T_LOGIC};
            c_FN_NOR: f_rfn = {2'b11,    c_T_LOGIC};
            c_FN_SLT: f_rfn = {2'b01,    c_T_SLT};
            c_FN_SLL: f_rfn = {c_SH_SLL, c_T_SHIFT};
            c_FN_SRL: f_rfn = {c_SH_SRL, c_T_SHIFT};
            c_FN_SRA: f_rfn = {c_SH_SRA, c_T_SHIFT};
            default:  f_rfn = {2'b00,    c_T_ARITH};
        endcase
    endfunction

    // {LOGICFN, FNTYPE} for immediate ALU opcodes; addi is the fallback.
    function automatic logic [3:0] f_ifn(input logic [5:0] op);
        case (op)
            c_OP_SLTI: f_ifn = {2'b01, c_T_SLT};
            c_OP_ANDI: f_ifn = {2'b00, c_T_LOGIC};
            c_OP_ORI:  f_ifn = {2'b01, c_T_LOGIC};
            c_OP_XORI: f_ifn = {2'b10, c_T_LOGIC};
            default:   f_ifn = {2'b00, c_T_ARITH};
        endcase
    endfunction

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Timeout fires in the last permitted wait cycle only if no ack arrives;
    // an ack in that same cycle completes the access normally.
    assign w_tmo     = w_wait_st && !bus.mem_ack && (r_wait == c_WAIT_LAST);
    assign w_ovf_op  = ((r_state == S_EXEC_R) && ((r_fn_q == c_FN_ADD) || (r_fn_q == c_FN_SUB)))
                    || ((r_state == S_EXEC_I) && (r_op_q == c_OP_ADDI));
    assign w_br_ne   = (r_op_q == c_OP_BNE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
            r_op_q  <= '0;
            r_fn_q  <= '0;
            r_ovf_q <= 1'b0;
            r_wait  <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE) begin
                r_op_q <= bus.op;
                r_fn_q <= bus.fn;
            end
            if ((r_state == S_EXEC_R) || (r_state == S_EXEC_I)) begin
                r_ovf_q <= bus.ovfl & w_ovf_op;
            end
            // Counter runs only while a wait state is held; any exit clears it.
            if (w_wait_st && !bus.mem_ack && !w_tmo) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            // Cause is captured on entry and held for the whole EXC visit.
            if ((w_state_nxt == S_EXC) && (r_state != S_EXC)) begin
                r_cause <= w_cause_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_ctrl      = '0;
        w_mem_req   = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        case (r_state)
            S_RST: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 into PC while the instruction word is read.
                w_ctrl[c_B_INST_WR] = 1'b1;
                w_ctrl[c_B_PC_WR]   = 1'b1;
                w_ctrl[c_B_MEM_RD]  = 1'b1;
                w_mem_req           = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_we     = 1'b1;
                    w_pc_we     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_tmo) begin
                    w_state_nxt = S_EXC;
                    w_cause_nxt = c_CAUSE_BUS;
                end
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm << 2) into Z.
                w_ctrl[c_F_SRCY +: 2] = c_Y_IMM2;
                if (bus.op == c_OP_RTYPE) begin
                    case (bus.fn)
                        c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_XOR,
                        c_FN_NOR, c_FN_SLT, c_FN_SLL, c_FN_SRL, c_FN_SRA:
                                  w_state_nxt = S_EXEC_R;
                        c_FN_JR:  w_state_nxt = S_JUMP;
                        c_FN_SYS: begin
                            w_state_nxt = S_EXC;
                            w_cause_nxt = c_CAUSE_SYS;
                        end
                        default: begin
                            w_state_nxt = S_EXC;
                            w_cause_nxt = c_CAUSE_ILL;
                        end
                    endcase
                end else begin
                    case (bus.op)
                        c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI, c_OP_XORI:
                                            w_state_nxt = S_EXEC_I;
                        c_OP_LW, c_OP_SW:   w_state_nxt = S_ADDR;
                        c_OP_BEQ, c_OP_BNE: w_state_nxt = S_BRANCH;
                        c_OP_J, c_OP_JAL:   w_state_nxt = S_JUMP;
                        default: begin
                            w_state_nxt = S_EXC;
                            w_cause_nxt = c_CAUSE_ILL;
                        end
                    endcase
                end
            end
            S_EXEC_R: begin
                w_ctrl[c_F_SRCX +: 2]   = c_X_X;
                w_ctrl[c_F_SRCY +: 2]   = c_Y_Y;
                w_ctrl[c_F_FNTYPE +: 4] = f_rfn(r_fn_q);
                w_state_nxt             = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_ctrl[c_F_SRCX +: 2]   = c_X_X;
                w_ctrl[c_F_SRCY +: 2]   = c_Y_IMM;
                w_ctrl[c_F_FNTYPE +: 4] = f_ifn(r_op_q);
                w_state_nxt             = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_ctrl[c_F_REGDST +: 2]  = (r_op_q == c_OP_RTYPE) ? c_DST_RD : c_DST_RT;
                w_ctrl[c_F_REGDATA +: 2] = c_DATA_Z;
                if (r_ovf_q && TRAP_ON_OVF) begin
                    w_state_nxt = S_EXC;
                    w_cause_nxt = c_CAUSE_OVF;
                end else begin
                    w_ctrl[c_B_REG_WR] = 1'b1;
                    w_state_nxt        = S_FETCH;
                end
            end
            S_ADDR: begin
                w_ctrl[c_F_SRCX +: 2] = c_X_X;
                w_ctrl[c_F_SRCY +: 2] = c_Y_IMM;
                w_state_nxt           = (r_op_q == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_ctrl[c_B_IORD]   = 1'b1;
                w_ctrl[c_B_MEM_RD] = 1'b1;
                w_mem_req          = 1'b1;
                if (bus.mem_ack) begin
                    w_state_nxt = S_WB_MEM;
                end else if (w_tmo) begin
                    w_state_nxt = S_EXC;
                    w_cause_nxt = c_CAUSE_BUS;
                end
            end
            S_MEMWR: begin
                w_ctrl[c_B_IORD]   = 1'b1;
                w_ctrl[c_B_MEM_WR] = 1'b1;
                w_mem_req          = 1'b1;
                if (bus.mem_ack) begin
                    w_state_nxt = S_FETCH;
                end else if (w_tmo) begin
                    w_state_nxt = S_EXC;
                    w_cause_nxt = c_CAUSE_BUS;
                end
            end
            S_WB_MEM: begin
                w_ctrl[c_B_REG_WR]       = 1'b1;
                w_ctrl[c_F_REGDST +: 2]  = c_DST_RT;
                w_ctrl[c_F_REGDATA +: 2] = c_DATA_MEM;
                w_state_nxt              = S_FETCH;
            end
            S_BRANCH: begin
                // X - Y compare; Z already holds the target from DECODE.
                w_ctrl[c_F_SRCX +: 2]   = c_X_X;
                w_ctrl[c_F_SRCY +: 2]   = c_Y_Y;
                w_ctrl[c_F_FNTYPE +: 4] = {2'b01, c_T_ARITH};
                w_ctrl[c_B_PC_WR_BR]    = 1'b1;
                w_ctrl[c_B_BR_NE]       = w_br_ne;
                w_ctrl[c_F_PCSRC +: 2]  = c_PC_Z;
                w_pc_we                 = bus.alu_zero ^ w_br_ne;
                w_state_nxt             = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl[c_B_PC_WR]      = 1'b1;
                w_ctrl[c_F_PCSRC +: 2] = (r_op_q == c_OP_RTYPE) ? c_PC_X : c_PC_JT;
                w_pc_we                = 1'b1;
                if (r_op_q == c_OP_JAL) begin
                    w_ctrl[c_B_REG_WR]       = 1'b1;
                    w_ctrl[c_F_REGDST +: 2]  = c_DST_R31;
                    w_ctrl[c_F_REGDATA +: 2] = c_DATA_PC;
                end
                w_state_nxt = S_FETCH;
            end
            S_EXC: begin
                if (bus.exc_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    assign bus.ctrl_out  = w_ctrl;
    assign bus.mem_req   = w_mem_req;
    assign bus.ir_we     = w_ir_we;
    assign bus.pc_we     = w_pc_we;
    assign bus.exc_valid = (r_state == S_EXC);
    assign bus.exc_cause = (r_state == S_EXC) ? r_cause : 2'b00;
    assign bus.state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_fsm
//  Purpose  : Self-checking bench for mc_ctrl_fsm. Each scripted cycle pushes
//             the expected outputs into a scoreboard queue; a monitor pops
//             and compares them on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_EXEC_I = 4'd4;
    localparam logic [3:0] ST_ADDR   = 4'd5;
    localparam logic [3:0] ST_MEMRD  = 4'd6;
    localparam logic [3:0] ST_MEMWR  = 4'd7;
    localparam logic [3:0] ST_WB_MEM = 4'd8;
    localparam logic [3:0] ST_WB_ALU = 4'd9;
    localparam logic [3:0] ST_BRANCH = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_EXC    = 4'd12;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [21:0] ctrl;
        logic        mreq;
        logic        irwe;
        logic        pcwe;
        logic [1:0]  ec;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t sb_q[$];

    mc_ctrl_fsm_if #(.CTRL_W(22)) bus ();

    mc_ctrl_fsm #(
        .CTRL_W      (22),
        .MEM_TIMEOUT (16),
        .TRAP_ON_OVF (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_eq({e.tag, ".state"},     32'(bus.state_dbg), 32'(e.st));
            chk_eq({e.tag, ".ctrl"},      32'(bus.ctrl_out),  32'(e.ctrl));
            chk_eq({e.tag, ".mem_req"},   32'(bus.mem_req),   32'(e.mreq));
            chk_eq({e.tag, ".ir_we"},     32'(bus.ir_we),     32'(e.irwe));
            chk_eq({e.tag, ".pc_we"},     32'(bus.pc_we),     32'(e.pcwe));
            chk_eq({e.tag, ".exc_valid"}, 32'(bus.exc_valid), 32'(e.st == ST_EXC));
            chk_eq({e.tag, ".exc_cause"}, 32'(bus.exc_cause), 32'(e.ec));
        end
    end

    // One clock cycle: inputs are already set; queue what the DUT must show.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [21:0] ctrl,
                       input logic mreq, input logic irwe, input logic pcwe,
                       input logic [1:0] ec);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ctrl = ctrl;
        e.mreq = mreq;
        e.irwe = irwe;
        e.pcwe = pcwe;
        e.ec   = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        bus.mem_ack = 1'b0;
        repeat (waits) cyc("fetch", ST_FETCH, 22'h004300, 1'b1, 1'b0, 1'b0, 2'b00);
        bus.mem_ack = 1'b1;
        cyc("fetch_ack", ST_FETCH, 22'h004300, 1'b1, 1'b1, 1'b1, 2'b00);
        bus.mem_ack = 1'b0;
    endtask

    task automatic decode();
        cyc("decode", ST_DECODE, 22'h000030, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic exc(input logic [1:0] cause, input int waits);
        bus.exc_ack = 1'b0;
        repeat (waits) cyc("exc_hold", ST_EXC, 22'h0, 1'b0, 1'b0, 1'b0, cause);
        bus.exc_ack = 1'b1;
        cyc("exc_ack", ST_EXC, 22'h0, 1'b0, 1'b0, 1'b0, cause);
        bus.exc_ack = 1'b0;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        bus.op = op;
        bus.fn = fn;
    endtask

    initial begin
        reset        = 1'b1;
        bus.op       = 6'd0;
        bus.fn       = 6'd0;
        bus.alu_zero = 1'b0;
        bus.ovfl     = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.exc_ack  = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then release into FETCH.
        cyc("rst_hold", ST_RST, 22'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        cyc("rst_rel", ST_RST, 22'h0, 1'b0, 1'b0, 1'b0, 2'b00);

        // add: ack on third FETCH cycle.
        set_ir(6'd0, 6'd32);
        fetch(2);
        decode();
        cyc("add_exec", ST_EXEC_R, 22'h000050, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("add_wb",   ST_WB_ALU, 22'h060000, 1'b0, 1'b0, 1'b0, 2'b00);

        // sub with overflow traps, no register write, cause held until ack.
        set_ir(6'd0, 6'd34);
        fetch(0);
        decode();
        bus.ovfl = 1'b1;
        cyc("sub_exec", ST_EXEC_R, 22'h000054, 1'b0, 1'b0, 1'b0, 2'b00);
        bus.ovfl = 1'b0;
        cyc("sub_wb_trap", ST_WB_ALU, 22'h040000, 1'b0, 1'b0, 1'b0, 2'b00);
        exc(2'b10, 3);

        // addi without overflow writes rt.
        set_ir(6'd8, 6'd0);
        fetch(0);
        decode();
        cyc("addi_exec", ST_EXEC_I, 22'h000060, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("addi_wb",   ST_WB_ALU, 22'h020000, 1'b0, 1'b0, 1'b0, 2'b00);

        // beq taken, bne with zero not taken, bne with nonzero taken.
        set_ir(6'd4, 6'd0);
        fetch(0);
        decode();
        bus.alu_zero = 1'b1;
        cyc("beq_z", ST_BRANCH, 22'h001454, 1'b0, 1'b0, 1'b1, 2'b00);
        set_ir(6'd5, 6'd0);
        fetch(0);
        decode();
        cyc("bne_z", ST_BRANCH, 22'h001C54, 1'b0, 1'b0, 1'b0, 2'b00);
        fetch(0);
        decode();
        bus.alu_zero = 1'b0;
        cyc("bne_nz", ST_BRANCH, 22'h001C54, 1'b0, 1'b0, 1'b1, 2'b00);

        // jal and jr.
        set_ir(6'd3, 6'd0);
        fetch(0);
        decode();
        cyc("jal", ST_JUMP, 22'h2A2200, 1'b0, 1'b0, 1'b1, 2'b00);
        set_ir(6'd0, 6'd8);
        fetch(0);
        decode();
        cyc("jr", ST_JUMP, 22'h003200, 1'b0, 1'b0, 1'b1, 2'b00);

        // lw with no ack: 16 MEMRD cycles then bus-timeout trap.
        set_ir(6'd35, 6'd0);
        fetch(0);
        decode();
        cyc("lw_addr", ST_ADDR, 22'h000060, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (16) cyc("lw_wait", ST_MEMRD, 22'h014000, 1'b1, 1'b0, 1'b0, 2'b00);
        exc(2'b00, 1);

        // lw with ack on the 16th cycle completes normally.
        fetch(0);
        decode();
        cyc("lw2_addr", ST_ADDR, 22'h000060, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (15) cyc("lw2_wait", ST_MEMRD, 22'h014000, 1'b1, 1'b0, 1'b0, 2'b00);
        bus.mem_ack = 1'b1;
        cyc("lw2_ack", ST_MEMRD, 22'h014000, 1'b1, 1'b0, 1'b0, 2'b00);
        bus.mem_ack = 1'b0;
        cyc("lw2_wb", ST_WB_MEM, 22'h120000, 1'b0, 1'b0, 1'b0, 2'b00);

        // sw acked immediately.
        set_ir(6'd43, 6'd0);
        fetch(0);
        decode();
        cyc("sw_addr", ST_ADDR, 22'h000060, 1'b0, 1'b0, 1'b0, 2'b00);
        bus.mem_ack = 1'b1;
        cyc("sw_mem", ST_MEMWR, 22'h018000, 1'b1, 1'b0, 1'b0, 2'b00);
        bus.mem_ack = 1'b0;

        // Illegal opcode and syscall.
        set_ir(6'h3F, 6'd0);
        fetch(0);
        decode();
        exc(2'b01, 1);
        set_ir(6'd0, 6'd12);
        fetch(0);
        decode();
        exc(2'b11, 0);

        // Reset in the middle of MEMRD.
        set_ir(6'd35, 6'd0);
        fetch(0);
        decode();
        cyc("rm_addr", ST_ADDR, 22'h000060, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("rm_wait", ST_MEMRD, 22'h014000, 1'b1, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        cyc("rm_rst_in", ST_MEMRD, 22'h014000, 1'b1, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        cyc("rm_rst", ST_RST, 22'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        fetch(1);

        chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
